data_memory_arbiter: RTL and testbench

- Shares one single-port DataMemory between NUM_REQ CGRA memory-access PEs.
- Uses round-robin arbitration with a valid/ready request handshake and a fixed-latency read response.
- Includes a clear sequencer that zero-fills the memory on command; requesters are blocked while it runs.
- Sits between the PE array's load/store units and the memory instance.

---
 rtl/data_memory_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_data_memory_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - round-robin arbiter and zero-fill sequencer for a shared DataMemory
//
// Purpose:
//   Shares one single-port DataMemory between NUM_REQ CGRA load/store PEs.
//   Each cycle at most one requester is granted, round-robin from rr_ptr.
//   Loads return data one cycle after the grant on a one-hot rsp_valid strobe.
//   A clear command sweeps addresses 0..MEMORY_SIZE-1 writing zero while
//   all requesters are held off.
//
// Optional build macro:
//   DATA_MEMORY_ARBITER_STATS_EN adds saturating stat_grants / stat_stalls counters.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   req_valid/req_ready         per-requester handshake (transfer on valid&ready)
//   req_write                   per-requester 1=store, 0=load
//   req_address, req_data       packed per-requester address / store data
//   rsp_valid, rsp_data         one-hot load response strobe and shared load data
//   clear_start                 pulse to start the zero-fill
//   clear_busy, clear_done      zero-fill in progress / one-cycle completion pulse
//   mem_address, mem_write,
//   mem_input_data              memory command
//   mem_output_data             registered memory read data (1-cycle latency)
//   stat_grants, stat_stalls    statistics (only with DATA_MEMORY_ARBITER_STATS_EN)

module data_memory_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int MEMORY_SIZE   = 1024
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  input  logic                             clear_start,
  output logic                             clear_busy,
  output logic                             clear_done,
  output logic [ADDRESS_WIDTH-1:0]         mem_address,
  output logic                             mem_write,
  output logic [DATA_WIDTH-1:0]            mem_input_data,
  input  logic [DATA_WIDTH-1:0]            mem_output_data
`ifdef DATA_MEMORY_ARBITER_STATS_EN
  ,
  output logic [31:0]                      stat_grants,
  output logic [31:0]                      stat_stalls
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDRESS_WIDTH-1:0] CLEAR_LAST = ADDRESS_WIDTH'(MEMORY_SIZE - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t                   state, state_d;
  logic [PTR_W-1:0]         rr_ptr, rr_ptr_d;
  logic [ADDRESS_WIDTH-1:0] clear_cnt, clear_cnt_d;
  logic [NUM_REQ-1:0]       rsp_valid_d;
  logic [NUM_REQ-1:0]       req_valid_eff;
  logic                     grant_found;
  logic [PTR_W-1:0]         grant_idx;
  logic [PTR_W-1:0]         grant_next;
  logic [PTR_W:0]           cand;
  logic                     grant_taken;

  // Requests are invisible while reset is held so nothing is granted or written.
  assign req_valid_eff = req_valid & {NUM_REQ{~reset}};

  // Load data is taken straight from the memory's output register.
  assign rsp_data = mem_output_data;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_REQ)) begin
        cand = cand - (PTR_W+1)'(NUM_REQ);
      end
      if (!grant_found && req_valid_eff[cand[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[PTR_W-1:0];
      end
    end
  end

  assign grant_next = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);

  always_comb begin
    state_d        = state;
    rr_ptr_d       = rr_ptr;
    clear_cnt_d    = clear_cnt;
    rsp_valid_d    = '0;
    req_ready      = '0;
    clear_busy     = 1'b0;
    clear_done     = 1'b0;
    mem_address    = '0;
    mem_write      = 1'b0;
    mem_input_data = '0;
    grant_taken    = 1'b0;
    case (state)
      IDLE: begin
        if (clear_start && !reset) begin
          // Clear wins over any pending request this cycle.
          state_d     = CLEAR;
          clear_cnt_d = '0;
        end else if (grant_found) begin
          grant_taken            = 1'b1;
          req_ready[grant_idx]   = 1'b1;
          mem_address            = req_address[grant_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          mem_write              = req_write[grant_idx];
          mem_input_data         = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
          rsp_valid_d[grant_idx] = ~req_write[grant_idx];
          rr_ptr_d               = grant_next;
        end
      end
      CLEAR: begin
        clear_busy  = 1'b1;
        mem_write   = 1'b1;
        mem_address = clear_cnt;
        if (clear_cnt == CLEAR_LAST) begin
          clear_done  = 1'b1;
          state_d     = IDLE;
          clear_cnt_d = '0;
        end else begin
          clear_cnt_d = clear_cnt + ADDRESS_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      clear_cnt <= '0;
      rsp_valid <= '0;
    end else begin
      state     <= state_d;
      rr_ptr    <= rr_ptr_d;
      clear_cnt <= clear_cnt_d;
      rsp_valid <= rsp_valid_d;
    end
  end

`ifdef DATA_MEMORY_ARBITER_STATS_EN
  logic stall;

  // A stall is any cycle where a valid requester goes unserved; during CLEAR
  // every valid requester is unserved.
  assign stall = (state == CLEAR) ? |req_valid : |(req_valid & ~req_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_grants <= '0;
      stat_stalls <= '0;
    end else if (state == IDLE && clear_start) begin
      stat_grants <= '0;
      stat_stalls <= '0;
    end else begin
      if (grant_taken && stat_grants != '1) begin
        stat_grants <= stat_grants + 32'd1;
      end
      if (stall && stat_stalls != '1) begin
        stat_stalls <= stat_stalls + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb/tb_data_memory_arbiter.sv - directed self-checking bench for data_memory_arbiter

module tb_data_memory_arbiter;

  localparam int NR = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int MS = 1024;

  logic            clk;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   req_write;
  logic [NR*AW-1:0] req_address;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            clear_start;
  logic            clear_busy;
  logic            clear_done;
  logic [AW-1:0]   mem_address;
  logic            mem_write;
  logic [DW-1:0]   mem_input_data;
  logic [DW-1:0]   mem_output_data;
`ifdef DATA_MEMORY_ARBITER_STATS_EN
  logic [31:0]     stat_grants;
  logic [31:0]     stat_stalls;
`endif

  int tests;
  int errors;

  data_memory_arbiter #(
    .NUM_REQ(NR), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MEMORY_SIZE(MS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_address(req_address),
    .req_data(req_data),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .clear_start(clear_start),
    .clear_busy(clear_busy),
    .clear_done(clear_done),
    .mem_address(mem_address),
    .mem_write(mem_write),
    .mem_input_data(mem_input_data),
    .mem_output_data(mem_output_data)
`ifdef DATA_MEMORY_ARBITER_STATS_EN
    ,
    .stat_grants(stat_grants),
    .stat_stalls(stat_stalls)
`endif
  );

  // Single-port memory: registered read, output held on write cycles.
  logic [DW-1:0] mem [0:MS-1];
  always @(posedge clk) begin
    if (mem_write) mem[mem_address[9:0]] <= mem_input_data;
    else           mem_output_data <= mem[mem_address[9:0]];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]           = v;
    req_write[i]           = w;
    req_address[i*AW +: AW] = a;
    req_data[i*DW +: DW]    = d;
  endtask

  task automatic idle_inputs();
    req_valid   = '0;
    req_write   = '0;
    req_address = '0;
    req_data    = '0;
    clear_start = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    req_valid = 4'hF;
    #2;
    tests++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    tests++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %b expected 0", mem_write); end
    tick();
    tests++; if (rsp_valid !== 4'h0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
    tests++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL reset_clear_busy: got %b expected 0", clear_busy); end
    tests++; if (clear_done !== 1'b0) begin errors++; $display("FAIL reset_clear_done: got %b expected 0", clear_done); end
    tests++; if (mem_address !== 16'h0) begin errors++; $display("FAIL reset_mem_address: got %h expected 0000", mem_address); end
    tests++; if (mem_input_data !== 32'h0) begin errors++; $display("FAIL reset_mem_input_data: got %h expected 0", mem_input_data); end
    req_valid = '0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 1'b1, 1'b1, 16'd5, 32'hDEADBEEF);
    #1;
    tests++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_store_ready: got %b expected 0001", req_ready); end
    tests++; if (mem_write !== 1'b1 || mem_address !== 16'd5 || mem_input_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_store_cmd: got w=%b a=%h d=%h expected w=1 a=0005 d=deadbeef", mem_write, mem_address, mem_input_data);
    end
    tick();
    set_req(0, 1'b1, 1'b0, 16'd5, 32'h0);
    #1;
    tests++; if (req_ready !== 4'b0001 || mem_write !== 1'b0) begin errors++; $display("FAIL single_load_grant: got ready=%b w=%b expected 0001 0", req_ready, mem_write); end
    tick();
    set_req(0, 1'b0, 1'b0, 16'd0, 32'h0);
    tests++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid: got %b expected 0001", rsp_valid); end
    tests++; if (rsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rsp_data: got %h expected deadbeef", rsp_data); end
    tick();
    tests++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_rsp_clear: got %b expected 0000", rsp_valid); end
    // Out-of-range address passes straight through.
    set_req(1, 1'b1, 1'b0, 16'hFFFF, 32'h0);
    #1;
    tests++; if (mem_address !== 16'hFFFF) begin errors++; $display("FAIL out_of_range_addr: got %h expected ffff", mem_address); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, AW'(i), 32'h0);
    for (int k = 0; k < 8; k++) begin
      exp = 4'b0001 << (k % 4);
      #1;
      tests++; if (req_ready !== exp) begin errors++; $display("FAIL rr_grant_%0d: got %b expected %b", k, req_ready, exp); end
      if (k > 0) begin
        exp = 4'b0001 << ((k - 1) % 4);
        tests++; if (rsp_valid !== exp) begin errors++; $display("FAIL rr_rsp_%0d: got %b expected %b", k, rsp_valid, exp); end
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_rr_skip();
    logic [3:0] exp;
    // rr_ptr is 0 here; one grant to req1 moves it to 2.
    set_req(1, 1'b1, 1'b0, 16'd1, 32'h0);
    tick();
    idle_inputs();
    set_req(1, 1'b1, 1'b0, 16'd1, 32'h0);
    set_req(3, 1'b1, 1'b0, 16'd3, 32'h0);
    for (int k = 0; k < 3; k++) begin
      exp = (k == 1) ? 4'b0010 : 4'b1000;
      #1;
      tests++; if (req_ready !== exp) begin errors++; $display("FAIL rr_skip_%0d: got %b expected %b", k, req_ready, exp); end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_clear();
    int busy_cnt;
    int done_cnt;
    int done_idx;
    int ready_bad;
    do_reset();
    set_req(0, 1'b1, 1'b1, 16'd7, 32'h1234);
    tick();
    // rr_ptr is now 1. Clear wins over pending req0/req2 loads.
    set_req(0, 1'b1, 1'b0, 16'd7, 32'h0);
    set_req(2, 1'b1, 1'b0, 16'd2, 32'h0);
    clear_start = 1'b1;
    #1;
    tests++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL clear_start_ready: got %b expected 0000", req_ready); end
    tick();
    clear_start = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_idx = -1; ready_bad = 0;
    for (int c = 0; c < 2000; c++) begin
      if (clear_busy !== 1'b1) break;
      busy_cnt++;
      if (req_ready !== 4'b0000) ready_bad++;
      if (clear_done === 1'b1) begin done_cnt++; done_idx = busy_cnt; end
      clear_start = (busy_cnt == 500);
      tick();
    end
    clear_start = 1'b0;
    tests++; if (busy_cnt != MS) begin errors++; $display("FAIL clear_busy_len: got %0d expected %0d", busy_cnt, MS); end
    tests++; if (ready_bad != 0) begin errors++; $display("FAIL clear_ready_low: got %0d bad cycles expected 0", ready_bad); end
    tests++; if (done_cnt != 1 || done_idx != MS) begin errors++; $display("FAIL clear_done_pulse: got count=%0d at=%0d expected 1 at %0d", done_cnt, done_idx, MS); end
    #1;
    // rr_ptr preserved (1): with req0 and req2 valid, req2 wins.
    tests++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL clear_rr_keep: got %b expected 0100", req_ready); end
    tick();
    set_req(2, 1'b0, 1'b0, 16'd0, 32'h0);
    tick();
    idle_inputs();
    tests++; if (rsp_valid !== 4'b0001 || rsp_data !== 32'h0) begin errors++; $display("FAIL clear_load_zero: got v=%b d=%h expected 0001 00000000", rsp_valid, rsp_data); end
    tick();
  endtask

  task automatic test_reset_mid_clear();
    int done_cnt;
    do_reset();
    set_req(0, 1'b1, 1'b1, 16'd3, 32'hAAAAAAAA);
    tick();
    set_req(0, 1'b1, 1'b1, 16'd900, 32'h55555555);
    tick();
    idle_inputs();
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (clear_done === 1'b1) done_cnt++;
      tick();
    end
    reset = 1'b1;
    #1;
    tests++; if (clear_busy !== 1'b0 || clear_done !== 1'b0 || mem_write !== 1'b0) begin
      errors++; $display("FAIL mid_clear_reset: got busy=%b done=%b w=%b expected 0 0 0", clear_busy, clear_done, mem_write);
    end
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (clear_done === 1'b1) done_cnt++;
      tick();
    end
    tests++; if (done_cnt != 0) begin errors++; $display("FAIL mid_clear_no_done: got %0d expected 0", done_cnt); end
    set_req(0, 1'b1, 1'b0, 16'd3, 32'h0);
    tick();
    set_req(0, 1'b1, 1'b0, 16'd900, 32'h0);
    tests++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL mid_clear_addr3: got %h expected 00000000", rsp_data); end
    tick();
    idle_inputs();
    tests++; if (rsp_data !== 32'h55555555) begin errors++; $display("FAIL mid_clear_addr900: got %h expected 55555555", rsp_data); end
    tick();
  endtask

`ifdef DATA_MEMORY_ARBITER_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, AW'(i), 32'h0);
    for (int k = 0; k < 4; k++) tick();
    idle_inputs();
    tick();
    tests++; if (stat_grants !== 32'd4) begin errors++; $display("FAIL stat_grants: got %0d expected 4", stat_grants); end
    tests++; if (stat_stalls !== 32'd4) begin errors++; $display("FAIL stat_stalls: got %0d expected 4", stat_stalls); end
  endtask
`endif

  initial begin
    tests  = 0;
    errors = 0;
    reset  = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_rr_skip();
    test_clear();
    test_reset_mid_clear();
`ifdef DATA_MEMORY_ARBITER_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
